main_mem_burst: RTL and testbench

- Byte-addressable, big-endian main memory model for the MIPS processor testbench; replaces the single-port fixed-size memory.
- Adds a synchronous reset, an explicit burst state machine, byte-enabled writes, a parametrised read latency and an out-of-range fault.
- Serves instruction fetch and data accesses from the processor and loader; bursts of 1/4/8/16 words are latched at request time.

---
 rtl/main_mem_pkg.sv | 31 +++
 rtl/mem_byte_array.sv | 31 +++
 rtl/main_mem_burst.sv | 163 ++++++++++++++++
 tb/tb_main_mem_burst.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared encodings and helpers for the burst-capable main memory model.
package main_mem_pkg;

   typedef enum logic [1:0] {
      ACC_1W  = 2'b00,
      ACC_4W  = 2'b01,
      ACC_8W  = 2'b10,
      ACC_16W = 2'b11
   } acc_size_t;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_WAIT,
      RD
   } state_t;

   localparam logic [31:0] DEFAULT_START_ADDRESS = 32'h8002_0000;

   function automatic logic [4:0] burst_len(input logic [1:0] acc_size);
      logic [4:0] n;
      case (acc_size_t'(acc_size))
         ACC_1W:  n = 5'd1;
         ACC_4W:  n = 5'd4;
         ACC_8W:  n = 5'd8;
         default: n = 5'd16;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised byte storage: four byte lanes with per-lane write enables and
// a combinational big-endian read port (lane 0 = lowest address = bits [31:24]).
module mem_byte_array
   import main_mem_pkg::*;
#(
   parameter int unsigned WORDS = 262144,
   parameter int unsigned WW    = 18
) (
   input  logic          clk,
   input  logic          we,
   input  logic [WW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wbe,
   input  logic [WW-1:0] raddr,
   output logic [31:0]   rdata
);

   for (genvar b = 0; b < 4; b++) begin : g_lane
      // Zeroed at time 0 only; reset never touches the contents.
      logic [7:0] lane [WORDS] = '{default: '0};

      always_ff @(posedge clk) begin
         if (we && wbe[3-b]) begin
            lane[waddr] <= wdata[31-8*b -: 8];
         end
      end

      assign rdata[31-8*b -: 8] = lane[raddr];
   end

endmodule

// File: rtl/main_mem_burst.sv
// Burst main memory for the MIPS testbench: 1/4/8/16-word read and write bursts,
// byte-enabled writes, configurable read latency and an out-of-range fault pulse.
module main_mem_burst
   import main_mem_pkg::*;
#(
   parameter int unsigned             ADDRESS_SIZE  = 32,
   parameter int unsigned             DATA_SIZE     = 32,
   parameter int unsigned             MEM_SIZE      = 1048576,
   parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = DEFAULT_START_ADDRESS,
   parameter int unsigned             READ_LATENCY  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    wren,
   input  logic [ADDRESS_SIZE-1:0] addr,
   input  logic [1:0]              acc_size,
   input  logic [DATA_SIZE-1:0]    d_in,
   input  logic [3:0]              be,
   output logic [DATA_SIZE-1:0]    d_out,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    err
);

   localparam int unsigned WORDS = MEM_SIZE / 4;
   localparam int unsigned WW    = $clog2(WORDS);
   localparam logic [ADDRESS_SIZE:0] MEM_END = (ADDRESS_SIZE+1)'(MEM_SIZE);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [3:0]              last_q, last_d;
   logic [1:0]              lat_q, lat_d;
   logic [WW-1:0]           addr_q, addr_d;
   logic [WW-1:0]           waddr, raddr, idx_word;
   logic                    we, issue, err_d;
   logic [4:0]              n_req;
   logic [ADDRESS_SIZE-1:0] idx_req;
   logic [ADDRESS_SIZE:0]   end_req;
   logic                    legal, window, req;
   logic [DATA_SIZE-1:0]    rdata;

   assign n_req    = burst_len(acc_size);
   assign idx_req  = addr - START_ADDRESS;
   assign idx_word = idx_req[WW+1:2];
   assign end_req  = {1'b0, idx_req} + (ADDRESS_SIZE+1)'({n_req, 2'b00});
   assign legal    = (addr >= START_ADDRESS) && (addr[1:0] == 2'b00) && (end_req <= MEM_END);

   // The cycle holding the last read beat also accepts a request, so bursts chain without a bubble.
   assign window = (state_q == IDLE) || ((state_q == RD) && (cnt_q == last_q));
   assign req    = en && window;
   assign busy   = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      waddr   = addr_q;
      raddr   = addr_q;
      we      = 1'b0;
      issue   = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         WR: begin
            we = 1'b1;
            if (cnt_q == last_q) begin
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q + 4'd1;
               addr_d = addr_q + WW'(1);
            end
         end
         RD_WAIT: begin
            if (lat_q == 2'd0) begin
               issue   = 1'b1;
               cnt_d   = '0;
               addr_d  = addr_q + WW'(1);
               state_d = RD;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         RD: begin
            if (cnt_q != last_q) begin
               issue  = 1'b1;
               cnt_d  = cnt_q + 4'd1;
               addr_d = addr_q + WW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      if (req) begin
         if (!legal) begin
            err_d = 1'b1;
         end else begin
            last_d = 4'(n_req - 5'd1);
            if (wren) begin
               we      = 1'b1;
               waddr   = idx_word;
               cnt_d   = 4'd1;
               addr_d  = idx_word + WW'(1);
               state_d = (n_req == 5'd1) ? IDLE : WR;
            end else if (READ_LATENCY == 1) begin
               issue   = 1'b1;
               raddr   = idx_word;
               cnt_d   = '0;
               addr_d  = idx_word + WW'(1);
               state_d = RD;
            end else begin
               lat_d   = 2'(READ_LATENCY - 2);
               cnt_d   = '0;
               addr_d  = idx_word;
               state_d = RD_WAIT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= '0;
         lat_q    <= '0;
         addr_q   <= '0;
         d_out    <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         lat_q    <= lat_d;
         addr_q   <= addr_d;
         err      <= err_d;
         rd_valid <= issue;
         if (issue) begin
            d_out <= rdata;
         end
      end
   end

   // Writes are gated by rst so a reset edge inside a write burst commits nothing.
   mem_byte_array #(
      .WORDS (WORDS),
      .WW    (WW)
   ) u_array (
      .clk   (clk),
      .we    (we && !rst),
      .waddr (waddr),
      .wdata (d_in),
      .wbe   (be),
      .raddr (raddr),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_main_mem_burst.sv
// Scoreboard bench: two instances (read latency 1 and 3) share stimulus; a byte model predicts read beats.
module tb_main_mem_burst;

   localparam logic [31:0] START = 32'h8002_0000;
   localparam int unsigned MSIZE = 1048576;
   localparam int          LAT_A = 1;
   localparam int          LAT_B = 3;
   localparam logic [31:0] ENDW  = START + MSIZE - 32;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en, wren, act_a, act_b, en_a, en_b;
   logic [31:0] addr, d_in;
   logic [1:0]  acc_size;
   logic [3:0]  be;
   logic [31:0] d_out_a, d_out_b;
   logic        rd_valid_a, rd_valid_b, busy_a, busy_b, err_a, err_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   exp_t qa[$];
   exp_t qb[$];
   bit [7:0] model [int unsigned];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign en_a = en & act_a;
   assign en_b = en & act_b;

   main_mem_burst #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .MEM_SIZE(MSIZE),
                    .START_ADDRESS(START), .READ_LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .wren(wren), .addr(addr), .acc_size(acc_size),
      .d_in(d_in), .be(be), .d_out(d_out_a), .rd_valid(rd_valid_a), .busy(busy_a), .err(err_a));

   main_mem_burst #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .MEM_SIZE(MSIZE),
                    .START_ADDRESS(START), .READ_LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .wren(wren), .addr(addr), .acc_size(acc_size),
      .d_in(d_in), .be(be), .d_out(d_out_b), .rd_valid(rd_valid_b), .busy(busy_b), .err(err_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int nlen(input logic [1:0] acc);
      case (acc)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 16;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input int unsigned off);
      return {model[off], model[off+1], model[off+2], model[off+3]};
   endfunction

   task automatic model_write(input int unsigned off, input logic [31:0] data, input logic [3:0] bm);
      for (int b = 0; b < 4; b++) begin
         if (bm[3-b]) model[off+b] = data[31-8*b -: 8];
      end
   endtask

   // Monitors pop one expected beat per rd_valid cycle and check data and arrival cycle.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rd_valid_a) begin
         if (qa.size() == 0) check("a_unexpected_beat", 32'd1, 32'd0);
         else begin
            e = qa.pop_front();
            check("a_data", d_out_a, e.data);
            check("a_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rd_valid_b) begin
         if (qb.size() == 0) check("b_unexpected_beat", 32'd1, 32'd0);
         else begin
            e = qb.pop_front();
            check("b_data", d_out_b, e.data);
            check("b_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic wr_burst(input logic [31:0] a, input logic [1:0] acc, input logic [31:0] base,
                           input logic [3:0] bm, input int abort_at);
      int n;
      bit aborted;
      n = nlen(acc);
      aborted = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("wr_busy_a", busy_a, 1);
            check("wr_busy_b", busy_b, 1);
         end
         if (k == abort_at) begin
            rst = 1'b1;
            en = 1'b0;
            aborted = 1'b1;
            break;
         end
         en = (k == 0);
         wren = 1'b1;
         addr = a;
         acc_size = acc;
         d_in = base + k;
         be = bm;
         model_write(a - START + 4 * k, base + k, bm);
      end
      @(negedge clk);
      en = 1'b0;
      wren = 1'b0;
      check("wr_end_busy_a", busy_a, 0);
      check("wr_end_busy_b", busy_b, 0);
      if (aborted) begin
         check("rst_rd_valid_a", rd_valid_a, 0);
         check("rst_rd_valid_b", rd_valid_b, 0);
         rst = 1'b0;
      end
   endtask

   task automatic rd_burst(input logic [31:0] a, input logic [1:0] acc, input bit on_b);
      exp_t e;
      int lat;
      lat = on_b ? LAT_B : LAT_A;
      @(negedge clk);
      act_a = !on_b;
      act_b = on_b;
      en = 1'b1;
      wren = 1'b0;
      addr = a;
      acc_size = acc;
      for (int k = 0; k < nlen(acc); k++) begin
         e.data = model_word(a - START + 4 * k);
         e.cyc = cyc + lat + k;
         if (on_b) qb.push_back(e);
         else qa.push_back(e);
      end
      @(negedge clk);
      en = 1'b0;
      act_a = 1'b1;
      act_b = 1'b1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         @(negedge clk);
      end
      check("drain_a", qa.size(), 0);
      check("drain_b", qb.size(), 0);
      @(negedge clk);
   endtask

   task automatic fault(input logic [31:0] a, input logic [1:0] acc, input logic w);
      @(negedge clk);
      en = 1'b1;
      wren = w;
      addr = a;
      acc_size = acc;
      d_in = 32'hBAD0_BAD0;
      be = 4'hF;
      @(negedge clk);
      en = 1'b0;
      check("fault_err_a", err_a, 1);
      check("fault_err_b", err_b, 1);
      check("fault_busy_a", busy_a, 0);
      check("fault_busy_b", busy_b, 0);
      check("fault_rdv_a", rd_valid_a, 0);
      @(negedge clk);
      check("fault_err_pulse_a", err_a, 0);
      check("fault_busy2_b", busy_b, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int c;
      rst = 1'b1; en = 1'b0; wren = 1'b0; act_a = 1'b1; act_b = 1'b1;
      addr = '0; d_in = '0; acc_size = '0; be = '0;
      repeat (3) @(negedge clk);
      check("rst_busy_a", busy_a, 0);
      check("rst_busy_b", busy_b, 0);
      check("rst_rdv_a", rd_valid_a, 0);
      check("rst_err_a", err_a, 0);
      check("rst_dout_a", d_out_a, 0);
      check("rst_dout_b", d_out_b, 0);
      rst = 1'b0;

      // Single-word write then latency-1 read
      wr_burst(START, 2'b00, 32'hDEAD_BEEF, 4'hF, 99);
      rd_burst(START, 2'b00, 1'b0);
      wait_drain();
      check("single_hold", d_out_a, 32'hDEAD_BEEF);

      // Byte enables
      wr_burst(START + 4, 2'b00, 32'h1122_3344, 4'hF, 99);
      wr_burst(START + 4, 2'b00, 32'hAABB_CCDD, 4'b0101, 99);
      rd_burst(START + 4, 2'b00, 1'b0);
      wait_drain();
      check("be_hold", d_out_a, 32'h11BB_33DD);

      // Burst of 4, latency-3 read with ignored en pulses
      wr_burst(START + 32'h10, 2'b01, 32'd0, 4'hF, 99);
      @(negedge clk);
      act_a = 1'b0; act_b = 1'b1;
      en = 1'b1; wren = 1'b0; addr = START + 32'h10; acc_size = 2'b01;
      c = cyc;
      for (int k = 0; k < 4; k++) begin
         e.data = model_word(32'h10 + 4 * k);
         e.cyc = c + LAT_B + k;
         qb.push_back(e);
      end
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         check("b4_busy", busy_b, (i <= 6) ? 1 : 0);
         check("b4_err", err_b, 0);
         en = (i == 2 || i == 4);
         wren = 1'b1;
         d_in = 32'hFFFF_FFFF;
         acc_size = 2'b00;
      end
      en = 1'b0; wren = 1'b0; act_a = 1'b1;
      wait_drain();
      check("b4_hold", d_out_b, 32'd3);
      rd_burst(START + 32'h10, 2'b00, 1'b1);
      wait_drain();

      // Faults
      fault(32'h8001_FFFC, 2'b00, 1'b0);
      fault(32'h8002_0002, 2'b00, 1'b1);
      fault(ENDW, 2'b11, 1'b0);
      rd_burst(START, 2'b00, 1'b0);
      wait_drain();

      // Reset in the middle of a 16-word write
      wr_burst(START + 32'h100, 2'b11, 32'h0101_0000, 4'hF, 99);
      wr_burst(START + 32'h100, 2'b11, 32'hA5A5_0000, 4'hF, 2);
      rd_burst(START + 32'h100, 2'b11, 1'b0);
      wait_drain();

      // Legal burst ending exactly at the top of memory, then back-to-back read/write
      wr_burst(ENDW, 2'b10, 32'h7700_0000, 4'hF, 99);
      @(negedge clk);
      act_a = 1'b1; act_b = 1'b0;
      en = 1'b1; wren = 1'b0; addr = ENDW; acc_size = 2'b10;
      c = cyc;
      for (int k = 0; k < 8; k++) begin
         e.data = model_word(ENDW - START + 4 * k);
         e.cyc = c + LAT_A + k;
         qa.push_back(e);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i < 8) en = 1'b0;
         else begin
            check("b2b_busy_last", busy_a, 1);
            en = 1'b1; wren = 1'b1; addr = ENDW; acc_size = 2'b00;
            d_in = 32'hC0FF_EE00; be = 4'hF;
            model_write(ENDW - START, 32'hC0FF_EE00, 4'hF);
         end
      end
      @(negedge clk);
      en = 1'b0; wren = 1'b0;
      check("b2b_busy_after", busy_a, 0);
      check("b2b_err", err_a, 0);
      act_b = 1'b1;
      wait_drain();
      rd_burst(ENDW, 2'b00, 1'b0);
      wait_drain();
      check("b2b_write_hold", d_out_a, 32'hC0FF_EE00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
